// File: rtl/fp16_add_lane_arb_if.sv
// Requester-side bundle for fp16_add_lane_arb: operand issue handshake plus the
// returned sum vector. The requester is the master; the arbiter is the slave.
interface fp16_add_lane_arb_if #(
  parameter int DW  = 16,
  parameter int PAR = 16,
  parameter int TW  = 10
);
  logic                valid;
  logic                ready;
  logic [PAR*DW-1:0]   a;
  logic [PAR*DW-1:0]   b;
  logic [TW-1:0]       tag;
  logic [PAR-1:0]      mask;
  logic                rsp_valid;
  logic [PAR*DW-1:0]   rsp_sum;
  logic [TW-1:0]       rsp_tag;
  logic [PAR-1:0]      rsp_mask;

  modport master (output valid, a, b, tag, mask,
                  input  ready, rsp_valid, rsp_sum, rsp_tag, rsp_mask);
  modport slave  (input  valid, a, b, tag, mask,
                  output ready, rsp_valid, rsp_sum, rsp_tag, rsp_mask);
endinterface

// File: rtl/fp16_add_lane_arb.sv
// Round-robin sharing of one external PAR-lane fp16 adder bank between two requesters,
// with a latency-matched owner/tag/mask pipe. Optional counters: define ARB_STATS_EN.
module fp16_add_lane_arb #(
  parameter int DW    = 16,
  parameter int PAR   = 16,
  parameter int A_LAT = 11,
  parameter int TW    = 10
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                enable_i,
  fp16_add_lane_arb_if.slave  req0_if,
  fp16_add_lane_arb_if.slave  req1_if,
  output logic [PAR*DW-1:0]   add_in1_flat_o,
  output logic [PAR*DW-1:0]   add_in2_flat_o,
  output logic                add_valid_in_o,
  input  logic [PAR*DW-1:0]   add_out_flat_i,
  input  logic                add_valid_out_i,
  output logic                busy_o,
  output logic                drained_o,
  output logic                err_o
`ifdef ARB_STATS_EN
  ,
  input  logic                stats_clr_i,
  output logic [31:0]         grant_cnt0_o,
  output logic [31:0]         grant_cnt1_o,
  output logic [31:0]         stall_cnt_o
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_e;

  function automatic logic [PAR*DW-1:0] apply_mask(input logic [PAR*DW-1:0] v,
                                                   input logic [PAR-1:0]    m);
    logic [PAR*DW-1:0] r;
    r = '0;
    for (int g = 0; g < PAR; g++) r[g*DW +: DW] = m[g] ? v[g*DW +: DW] : '0;
    return r;
  endfunction

  state_e            state_q, state_d;
  logic              rr_ptr_q, rr_ptr_d;
  logic              err_q, err_d;
  logic              run, gnt0, gnt1, gnt_any, hit, pipe_empty;

  logic [PAR*DW-1:0] add_in1_q, add_in2_q;
  logic              add_vld_q;

  logic [A_LAT:0]    pipe_vld_q;
  logic [A_LAT:0]    pipe_own_q;
  logic [TW-1:0]     pipe_tag_q  [A_LAT+1];
  logic [PAR-1:0]    pipe_mask_q [A_LAT+1];

  logic              rsp_vld0_q, rsp_vld1_q;
  logic [PAR*DW-1:0] rsp_sum0_q, rsp_sum1_q;
  logic [TW-1:0]     rsp_tag0_q, rsp_tag1_q;
  logic [PAR-1:0]    rsp_mask0_q, rsp_mask1_q;

  // Grant: the pointer only breaks ties; a lone valid requester always wins.
  assign run     = (state_q == S_RUN) && enable_i;
  assign gnt0    = run && req0_if.valid && (!req1_if.valid || !rr_ptr_q);
  assign gnt1    = run && req1_if.valid && (!req0_if.valid ||  rr_ptr_q);
  assign gnt_any = gnt0 | gnt1;
  assign hit     = add_valid_out_i & pipe_vld_q[A_LAT];

  assign pipe_empty = ~|pipe_vld_q & ~rsp_vld0_q & ~rsp_vld1_q;
  assign busy_o     = |pipe_vld_q | rsp_vld0_q | rsp_vld1_q | add_vld_q;
  assign err_d      = err_q | (add_valid_out_i != pipe_vld_q[A_LAT]);

  always_comb begin
    state_d   = state_q;
    drained_o = 1'b0;
    rr_ptr_d  = rr_ptr_q;
    if (run && req0_if.valid && req1_if.valid) rr_ptr_d = ~rr_ptr_q;
    case (state_q)
      S_IDLE:  if (enable_i) state_d = S_RUN;
      S_RUN:   if (!enable_i) state_d = S_DRAIN;
      S_DRAIN: begin
        if (enable_i) begin
          state_d = S_RUN;
        end else if (pipe_empty) begin
          state_d   = S_IDLE;
          drained_o = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= S_IDLE;
      rr_ptr_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      err_q    <= err_d;
    end
  end

  // Stage p0: issue register toward the adder bank, masked lanes forced to zero.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      add_in1_q <= '0;
      add_in2_q <= '0;
      add_vld_q <= 1'b0;
    end else begin
      add_vld_q <= gnt_any;
      if (gnt_any) begin
        add_in1_q <= apply_mask(gnt1 ? req1_if.a : req0_if.a, gnt1 ? req1_if.mask : req0_if.mask);
        add_in2_q <= apply_mask(gnt1 ? req1_if.b : req0_if.b, gnt1 ? req1_if.mask : req0_if.mask);
      end
    end
  end

  // Stages p0..pA_LAT: side-band pipe; the last entry lines up with add_valid_out.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pipe_vld_q <= '0;
      pipe_own_q <= '0;
      for (int i = 0; i <= A_LAT; i++) begin
        pipe_tag_q[i]  <= '0;
        pipe_mask_q[i] <= '0;
      end
    end else begin
      pipe_vld_q     <= {pipe_vld_q[A_LAT-1:0], gnt_any};
      pipe_own_q     <= {pipe_own_q[A_LAT-1:0], gnt1};
      pipe_tag_q[0]  <= gnt1 ? req1_if.tag  : req0_if.tag;
      pipe_mask_q[0] <= gnt1 ? req1_if.mask : req0_if.mask;
      for (int i = 1; i <= A_LAT; i++) begin
        pipe_tag_q[i]  <= pipe_tag_q[i-1];
        pipe_mask_q[i] <= pipe_mask_q[i-1];
      end
    end
  end

  // Response stage: a result with no matching pipe entry is dropped (err flags it).
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rsp_vld0_q  <= 1'b0;
      rsp_vld1_q  <= 1'b0;
      rsp_sum0_q  <= '0;
      rsp_sum1_q  <= '0;
      rsp_tag0_q  <= '0;
      rsp_tag1_q  <= '0;
      rsp_mask0_q <= '0;
      rsp_mask1_q <= '0;
    end else begin
      rsp_vld0_q <= hit & ~pipe_own_q[A_LAT];
      rsp_vld1_q <= hit &  pipe_own_q[A_LAT];
      if (hit && !pipe_own_q[A_LAT]) begin
        rsp_sum0_q  <= apply_mask(add_out_flat_i, pipe_mask_q[A_LAT]);
        rsp_tag0_q  <= pipe_tag_q[A_LAT];
        rsp_mask0_q <= pipe_mask_q[A_LAT];
      end
      if (hit && pipe_own_q[A_LAT]) begin
        rsp_sum1_q  <= apply_mask(add_out_flat_i, pipe_mask_q[A_LAT]);
        rsp_tag1_q  <= pipe_tag_q[A_LAT];
        rsp_mask1_q <= pipe_mask_q[A_LAT];
      end
    end
  end

  assign req0_if.ready     = gnt0;
  assign req1_if.ready     = gnt1;
  assign req0_if.rsp_valid = rsp_vld0_q;
  assign req0_if.rsp_sum   = rsp_sum0_q;
  assign req0_if.rsp_tag   = rsp_tag0_q;
  assign req0_if.rsp_mask  = rsp_mask0_q;
  assign req1_if.rsp_valid = rsp_vld1_q;
  assign req1_if.rsp_sum   = rsp_sum1_q;
  assign req1_if.rsp_tag   = rsp_tag1_q;
  assign req1_if.rsp_mask  = rsp_mask1_q;
  assign add_in1_flat_o    = add_in1_q;
  assign add_in2_flat_o    = add_in2_q;
  assign add_valid_in_o    = add_vld_q;
  assign err_o             = err_q;

`ifdef ARB_STATS_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] x);
    return (&x) ? x : x + 32'd1;
  endfunction

  logic [31:0] gcnt0_q, gcnt1_q, stall_q;
  logic        stall;

  assign stall = enable_i & ((req0_if.valid & ~gnt0) | (req1_if.valid & ~gnt1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      gcnt0_q <= '0;
      gcnt1_q <= '0;
      stall_q <= '0;
    end else if (stats_clr_i) begin
      gcnt0_q <= '0;
      gcnt1_q <= '0;
      stall_q <= '0;
    end else begin
      if (gnt0)  gcnt0_q <= sat_inc(gcnt0_q);
      if (gnt1)  gcnt1_q <= sat_inc(gcnt1_q);
      if (stall) stall_q <= sat_inc(stall_q);
    end
  end

  assign grant_cnt0_o = gcnt0_q;
  assign grant_cnt1_o = gcnt1_q;
  assign stall_cnt_o  = stall_q;
`endif

endmodule
